// File: rtl/router_sync_if.sv
// Port bundle between the router FSM, the three output FIFOs and router_sync.
// master drives the FSM/FIFO/port side, slave is the sync stage itself.
interface router_sync_if;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       read_enb_0;
  logic       read_enb_1;
  logic       read_enb_2;
  logic       empty_0;
  logic       empty_1;
  logic       empty_2;
  logic       full_0;
  logic       full_1;
  logic       full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0;
  logic       vld_out_1;
  logic       vld_out_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;

  modport master (
    output detect_add,
    output data_in,
    output write_enb_reg,
    output read_enb_0,
    output read_enb_1,
    output read_enb_2,
    output empty_0,
    output empty_1,
    output empty_2,
    output full_0,
    output full_1,
    output full_2,
    input  write_enb,
    input  fifo_full,
    input  vld_out_0,
    input  vld_out_1,
    input  vld_out_2,
    input  soft_reset_0,
    input  soft_reset_1,
    input  soft_reset_2
  );

  modport slave (
    input  detect_add,
    input  data_in,
    input  write_enb_reg,
    input  read_enb_0,
    input  read_enb_1,
    input  read_enb_2,
    input  empty_0,
    input  empty_1,
    input  empty_2,
    input  full_0,
    input  full_1,
    input  full_2,
    output write_enb,
    output fifo_full,
    output vld_out_0,
    output vld_out_1,
    output vld_out_2,
    output soft_reset_0,
    output soft_reset_1,
    output soft_reset_2
  );
endinterface

// File: rtl/router_sync.sv
// Address latch, FIFO write steering and per-port idle watchdogs
// sitting between the 1x3 router FSM and its three output FIFOs.
module router_sync #(
  parameter int TIMEOUT = 30,
  parameter int CW      = 6
) (
  input logic        clock,
  input logic        resetn,
  router_sync_if.slave bus
);

  logic [1:0]    int_addr;
  logic [2:0]    vld;
  logic [2:0]    rd;
  logic [2:0]    full;
  logic [2:0]    sr;
  logic [2:0]    sr_nxt;
  logic [CW-1:0] cnt [3];
  logic [CW-1:0] cnt_nxt [3];
  logic [2:0]    wen;
  logic          sel_full;

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  assign vld  = ~{bus.empty_2, bus.empty_1, bus.empty_0};
  assign rd   = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
  assign full = {bus.full_2, bus.full_1, bus.full_0};

  always_ff @(posedge clock) begin
    if (!resetn) begin
      int_addr <= 2'b11;
    end else if (bus.detect_add) begin
      int_addr <= bus.data_in;
    end
  end

  // Decode always uses the registered address, so a header arriving
  // alongside a write strobe only takes effect on the following cycle.
  always_comb begin
    wen      = 3'b000;
    sel_full = 1'b0;
    unique case (1'b1)
      (int_addr == 2'd0): begin
        wen[0]   = bus.write_enb_reg;
        sel_full = full[0];
      end
      (int_addr == 2'd1): begin
        wen[1]   = bus.write_enb_reg;
        sel_full = full[1];
      end
      (int_addr == 2'd2): begin
        wen[2]   = bus.write_enb_reg;
        sel_full = full[2];
      end
      default: begin
        wen      = 3'b000;
        sel_full = 1'b0;
      end
    endcase
  end

  assign bus.write_enb = wen;
  assign bus.fifo_full = sel_full & resetn;

  assign bus.vld_out_0 = vld[0];
  assign bus.vld_out_1 = vld[1];
  assign bus.vld_out_2 = vld[2];

  // Any read or an empty FIFO restarts the window from zero.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_nxt[i] = '0;
      sr_nxt[i]  = 1'b0;
      if (vld[i] && !rd[i]) begin
        if (cnt[i] == LAST) begin
          sr_nxt[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
      sr <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      sr <= sr_nxt;
    end
  end

  assign bus.soft_reset_0 = sr[0];
  assign bus.soft_reset_1 = sr[1];
  assign bus.soft_reset_2 = sr[2];

endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync: expectations are queued as stimulus
// is applied and checked once the DUT has responded.
module tb_router_sync;

  logic clock;
  logic resetn;
  logic [2:0] empty;
  logic [2:0] full;
  logic [2:0] rd;

  router_sync_if bus ();

  router_sync dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  assign bus.empty_0    = empty[0];
  assign bus.empty_1    = empty[1];
  assign bus.empty_2    = empty[2];
  assign bus.full_0     = full[0];
  assign bus.full_1     = full[1];
  assign bus.full_2     = full[2];
  assign bus.read_enb_0 = rd[0];
  assign bus.read_enb_1 = rd[1];
  assign bus.read_enb_2 = rd[2];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef enum int { S_WEN, S_FULL, S_SR, S_VLD } sig_t;

  typedef struct {
    string      tag;
    sig_t       sig;
    logic [2:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  function automatic logic [2:0] observe(sig_t s);
    case (s)
      S_WEN:  return bus.write_enb;
      S_FULL: return {2'b00, bus.fifo_full};
      S_SR:   return {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
      default:
        return {bus.vld_out_2, bus.vld_out_1, bus.vld_out_0};
    endcase
  endfunction

  task automatic push(input string tag, input sig_t s, input logic [2:0] e);
    exp_t x;
    x.tag = tag;
    x.sig = s;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    logic [2:0] obs;
    while (sb.size() > 0) begin
      x   = sb.pop_front();
      obs = observe(x.sig);
      vectors++;
      assert (obs === x.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%b expected=%b", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    drain();
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  initial begin
    vectors            = 0;
    miscompares        = 0;
    resetn             = 1'b0;
    empty              = 3'b111;
    full               = 3'b000;
    rd                 = 3'b000;
    bus.detect_add     = 1'b0;
    bus.data_in        = 2'b00;
    bus.write_enb_reg  = 1'b0;

    // reset held for two edges, strobes active
    bus.write_enb_reg = 1'b1;
    full              = 3'b111;
    tick();
    push("rst_wen", S_WEN, 3'b000);
    push("rst_full", S_FULL, 3'b000);
    push("rst_sr", S_SR, 3'b000);
    tick();
    resetn = 1'b1;
    push("post_rst_wen", S_WEN, 3'b000);
    push("post_rst_full", S_FULL, 3'b000);
    tick();

    // header 10 with write strobe: old address still decoded
    full           = 3'b000;
    bus.detect_add = 1'b1;
    bus.data_in    = 2'b10;
    push("hdr_same_cycle_wen", S_WEN, 3'b000);
    settle();
    tick();
    bus.detect_add = 1'b0;
    push("dec2_wen", S_WEN, 3'b100);
    push("dec2_full_lo", S_FULL, 3'b000);
    settle();
    full = 3'b100;
    push("dec2_full_hi", S_FULL, 3'b001);
    settle();
    full = 3'b011;
    push("dec2_other_full", S_FULL, 3'b000);
    settle();
    bus.write_enb_reg = 1'b0;
    push("dec2_no_strobe", S_WEN, 3'b000);
    settle();

    for (int i = 0; i < 2; i++) begin
      bus.detect_add    = 1'b1;
      bus.data_in       = 2'(i);
      bus.write_enb_reg = 1'b1;
      full              = 3'b000;
      tick();
      bus.detect_add = 1'b0;
      full           = 3'(1 << i);
      push($sformatf("dec%0d_wen", i), S_WEN, 3'(1 << i));
      push($sformatf("dec%0d_full_hi", i), S_FULL, 3'b001);
      settle();
      full = ~3'(1 << i);
      push($sformatf("dec%0d_full_lo", i), S_FULL, 3'b000);
      settle();
    end

    // invalid address never selects a FIFO
    bus.detect_add = 1'b1;
    bus.data_in    = 2'b11;
    tick();
    bus.detect_add = 1'b0;
    full           = 3'b111;
    push("inv_wen", S_WEN, 3'b000);
    push("inv_full", S_FULL, 3'b000);
    settle();
    full = 3'b000;

    empty = 3'b010;
    push("vld_101", S_VLD, 3'b101);
    settle();
    empty = 3'b111;
    push("vld_000", S_VLD, 3'b000);
    tick();

    // port 1 idle: pulse on edge 30 and again on edge 60
    empty = 3'b101;
    for (int k = 1; k <= 61; k++) begin
      bus.write_enb_reg = k[0];
      bus.detect_add    = (k % 7 == 0);
      bus.data_in       = 2'(k);
      push($sformatf("to_edge%0d", k), S_SR,
           (k == 30 || k == 60) ? 3'b010 : 3'b000);
      tick();
    end
    bus.write_enb_reg = 1'b0;
    bus.detect_add    = 1'b0;

    // restart: 29 idle, one read, then a full fresh window
    empty = 3'b111;
    push("rs_clear", S_SR, 3'b000);
    tick();
    empty = 3'b101;
    for (int k = 1; k <= 29; k++) begin
      push($sformatf("rs_pre%0d", k), S_SR, 3'b000);
      tick();
    end
    rd = 3'b010;
    push("rs_read", S_SR, 3'b000);
    tick();
    rd = 3'b000;
    for (int k = 1; k <= 31; k++) begin
      push($sformatf("rs_post%0d", k), S_SR,
           (k == 30) ? 3'b010 : 3'b000);
      tick();
    end

    // concurrent ports 0 and 2, reset on edge 15
    empty = 3'b111;
    tick();
    empty             = 3'b010;
    bus.write_enb_reg = 1'b1;
    for (int k = 1; k <= 46; k++) begin
      resetn = (k != 15);
      if (k < 45) begin
        push($sformatf("cc_edge%0d", k), S_SR, 3'b000);
      end else begin
        push($sformatf("cc_edge%0d", k), S_SR,
             (k == 45) ? 3'b101 : 3'b000);
      end
      if (k == 16) begin
        push("cc_addr_cleared", S_WEN, 3'b000);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
